// File: rtl/tipi_regs_pkg.sv
// Shared definitions for the TIPI write-side register block: register indices,
// FSM encoding and the select priority helper used by the commit logic.
package tipi_regs_pkg;

    localparam int NUM_REGS = 4;
    localparam int REG_A    = 0;
    localparam int REG_B    = 1;
    localparam int REG_C    = 2;
    localparam int REG_D    = 3;

    localparam logic [7:0] REG_RST_VAL = 8'h00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        COMMIT = 2'd2
    } wr_state_t;

    // A > B > C > D, same order as the read mux; all-zero means no target.
    function automatic logic [NUM_REGS-1:0] prio_onehot(input logic [NUM_REGS-1:0] sel);
        prio_onehot = '0;
        if (sel[REG_A])      prio_onehot[REG_A] = 1'b1;
        else if (sel[REG_B]) prio_onehot[REG_B] = 1'b1;
        else if (sel[REG_C]) prio_onehot[REG_C] = 1'b1;
        else if (sel[REG_D]) prio_onehot[REG_D] = 1'b1;
    endfunction

endpackage

// File: rtl/tipi_sync_pipe.sv
// N-stage, W-bit flip-flop synchronizer with a configurable reset value.
// All bits move together so a bus stays aligned with its strobe.
module tipi_sync_pipe #(
    parameter int           N       = 2,
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [N:0][W-1:0] chain;

    assign chain[0] = din;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_stage
            logic [W-1:0] stage_q;

            always_ff @(posedge clk) begin
                if (reset) stage_q <= RST_VAL;
                else       stage_q <= chain[gi];
            end

            assign chain[gi+1] = stage_q;
        end
    endgenerate

    assign dout = chain[N];

endmodule

// File: rtl/tipi_wreg_latch.sv
// TIPI write-side latch: synchronizes TI write strobes, filters glitches,
// commits the byte into registers A..D and tracks per-register pending flags.
module tipi_wreg_latch
    import tipi_regs_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_LOW     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ti_we_n,
    input  logic       a_addr,
    input  logic       b_addr,
    input  logic       c_addr,
    input  logic       d_addr,
    input  logic [7:0] ti_data,
    input  logic [3:0] pi_ack,
    output logic [7:0] a_reg,
    output logic [7:0] b_reg,
    output logic [7:0] c_reg,
    output logic [7:0] d_reg,
    output logic [3:0] wr_pulse,
    output logic [3:0] pending
);

    localparam int SW = 1 + NUM_REGS + 8;
    localparam int CW = $clog2(MIN_LOW + 1);
    localparam logic [CW-1:0] MIN_LOW_C = CW'(MIN_LOW);
    // Flushed pipeline reads as strobe released, nothing selected, data zero.
    localparam logic [SW-1:0] SYNC_RST = {1'b1, {(SW-1){1'b0}}};

    logic [SW-1:0]       sync_in;
    logic [SW-1:0]       sync_out;
    logic                we_s;
    logic [NUM_REGS-1:0] sel_s;
    logic [7:0]          dat_s;

    assign sync_in = {ti_we_n, d_addr, c_addr, b_addr, a_addr, ti_data};

    tipi_sync_pipe #(
        .N       (SYNC_STAGES),
        .W       (SW),
        .RST_VAL (SYNC_RST)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (sync_in),
        .dout  (sync_out)
    );

    assign we_s  = sync_out[SW-1];
    assign sel_s = sync_out[8 +: NUM_REGS];
    assign dat_s = sync_out[7:0];

    wr_state_t           state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NUM_REGS-1:0] sel_q, sel_d;
    logic [7:0]          dat_q, dat_d;
    logic [NUM_REGS-1:0] commit_mask;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            dat_q   <= REG_RST_VAL;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        dat_d       = dat_q;
        commit_mask = '0;
        case (state_q)
            IDLE: begin
                if (!we_s) begin
                    state_d = STROBE;
                    cnt_d   = CW'(1);
                    sel_d   = sel_s;
                    dat_d   = dat_s;
                end
            end
            STROBE: begin
                if (!we_s) begin
                    // Last low sample wins for both select and data.
                    sel_d = sel_s;
                    dat_d = dat_s;
                    if (cnt_q < MIN_LOW_C) cnt_d = cnt_q + CW'(1);
                end else begin
                    state_d = (cnt_q >= MIN_LOW_C) ? COMMIT : IDLE;
                    cnt_d   = '0;
                end
            end
            COMMIT: begin
                state_d     = IDLE;
                cnt_d       = '0;
                commit_mask = prio_onehot(sel_q);
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    logic [NUM_REGS-1:0][7:0] regs_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            always_ff @(posedge clk) begin
                if (reset)                regs_q[gi] <= REG_RST_VAL;
                else if (commit_mask[gi]) regs_q[gi] <= dat_q;
            end
        end
    endgenerate

    logic [NUM_REGS-1:0] wr_pulse_q;
    logic [NUM_REGS-1:0] pending_q, pending_d;

    // Set has priority over a simultaneous acknowledge.
    assign pending_d = (pending_q & ~pi_ack) | commit_mask;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_pulse_q <= '0;
            pending_q  <= '0;
        end else begin
            wr_pulse_q <= commit_mask;
            pending_q  <= pending_d;
        end
    end

    assign a_reg    = regs_q[REG_A];
    assign b_reg    = regs_q[REG_B];
    assign c_reg    = regs_q[REG_C];
    assign d_reg    = regs_q[REG_D];
    assign wr_pulse = wr_pulse_q;
    assign pending  = pending_q;

endmodule

// File: tb/tb_tipi_wreg_latch.sv
// Scoreboard bench for tipi_wreg_latch: directed strobes push hand-computed
// expectations; a monitor pops and compares on every wr_pulse.
module tb_tipi_wreg_latch;

    logic       clk = 1'b0;
    logic       reset;
    logic       ti_we_n;
    logic       a_addr, b_addr, c_addr, d_addr;
    logic [7:0] ti_data;
    logic [3:0] pi_ack;
    logic [7:0] a_reg, b_reg, c_reg, d_reg;
    logic [3:0] wr_pulse;
    logic [3:0] pending;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [3:0] pulse;
        logic [7:0] a, b, c, d;
        logic [3:0] pend;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];

    tipi_wreg_latch #(
        .SYNC_STAGES (2),
        .MIN_LOW     (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ti_we_n  (ti_we_n),
        .a_addr   (a_addr),
        .b_addr   (b_addr),
        .c_addr   (c_addr),
        .d_addr   (d_addr),
        .ti_data  (ti_data),
        .pi_ack   (pi_ack),
        .a_reg    (a_reg),
        .b_reg    (b_reg),
        .c_reg    (c_reg),
        .d_reg    (d_reg),
        .wr_pulse (wr_pulse),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
        end
    endtask

    task automatic check_state(input string tag, input logic [7:0] ea, eb, ec, ed,
                               input logic [3:0] ep);
        check({tag, " a_reg"},   32'(a_reg),   32'(ea));
        check({tag, " b_reg"},   32'(b_reg),   32'(eb));
        check({tag, " c_reg"},   32'(c_reg),   32'(ec));
        check({tag, " d_reg"},   32'(d_reg),   32'(ed));
        check({tag, " pending"}, 32'(pending), 32'(ep));
    endtask

    // Monitor: every non-zero wr_pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (wr_pulse !== 4'b0000) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got wr_pulse=%b expected none (cycle %0d)",
                         wr_pulse, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("mon wr_pulse", 32'(wr_pulse), 32'(e.pulse));
                check("mon latency",  32'(cyc),      32'(e.cyc));
                check_state("mon", e.a, e.b, e.c, e.d, e.pend);
            end
        end
    end

    // Low for `low` sampled edges; data d_first except on the last low edge.
    task automatic do_strobe(input logic [3:0] sel, input logic [7:0] d_first, d_last,
                             input int low, input logic [3:0] ack_commit,
                             input logic push, input logic [3:0] e_pulse,
                             input logic [7:0] ea, eb, ec, ed, input logic [3:0] e_pend);
        exp_t e;
        @(posedge clk); #1;
        {d_addr, c_addr, b_addr, a_addr} = sel;
        ti_we_n = 1'b0;
        for (int i = 0; i < low; i++) begin
            ti_data = (i == low - 1) ? d_last : d_first;
            @(posedge clk); #1;
        end
        ti_we_n = 1'b1;
        {d_addr, c_addr, b_addr, a_addr} = 4'b0000;
        ti_data = 8'h00;
        if (push) begin
            e.pulse = e_pulse;
            e.a = ea; e.b = eb; e.c = ec; e.d = ed;
            e.pend = e_pend;
            e.cyc  = cyc + 4;
            exp_q.push_back(e);
        end
        if (ack_commit != 4'b0000) begin
            repeat (3) @(posedge clk);
            #1 pi_ack = ack_commit;
            @(posedge clk);
            #1 pi_ack = 4'b0000;
        end
        repeat (8) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic ack_and_check(input logic [3:0] mask, input logic [3:0] e_pend);
        @(posedge clk); #1 pi_ack = mask;
        @(posedge clk); #1 pi_ack = 4'b0000;
        @(negedge clk);
        check("ack pending", 32'(pending), 32'(e_pend));
    endtask

    initial begin
        reset   = 1'b1;
        ti_we_n = 1'b1;
        {d_addr, c_addr, b_addr, a_addr} = 4'b0000;
        ti_data = 8'h00;
        pi_ack  = 4'b0000;
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset wr_pulse", 32'(wr_pulse), 32'h0);
        check_state("reset", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);

        // B write, 4-cycle strobe
        do_strobe(4'b0010, 8'h5A, 8'h5A, 4, 4'b0000, 1'b1,
                  4'b0010, 8'h00, 8'h5A, 8'h00, 8'h00, 4'b0010);
        ack_and_check(4'b0010, 4'b0000);

        // 1-cycle glitch on A
        do_strobe(4'b0001, 8'hFF, 8'hFF, 1, 4'b0000, 1'b0,
                  4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
        @(negedge clk);
        check_state("glitch", 8'h00, 8'h5A, 8'h00, 8'h00, 4'b0000);

        // A and C together: A wins
        do_strobe(4'b0101, 8'h3C, 8'h3C, 3, 4'b0000, 1'b1,
                  4'b0001, 8'h3C, 8'h5A, 8'h00, 8'h00, 4'b0001);

        // D with data changing during the strobe
        do_strobe(4'b1000, 8'h11, 8'h22, 4, 4'b0000, 1'b1,
                  4'b1000, 8'h3C, 8'h5A, 8'h00, 8'h22, 4'b1001);

        // D again, minimum width, ack[3] coincides with the commit: set wins
        do_strobe(4'b1000, 8'h44, 8'h44, 2, 4'b1000, 1'b1,
                  4'b1000, 8'h3C, 8'h5A, 8'h00, 8'h44, 4'b1001);
        ack_and_check(4'b1000, 4'b0001);
        ack_and_check(4'b0001, 4'b0000);

        // Reset while the FSM is mid-strobe on C
        @(posedge clk); #1;
        c_addr  = 1'b1;
        ti_data = 8'h77;
        ti_we_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset   = 1'b1;
        ti_we_n = 1'b1;
        c_addr  = 1'b0;
        ti_data = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_state("abort", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);

        // Clean C strobe after the aborted one
        do_strobe(4'b0100, 8'h77, 8'h77, 3, 4'b0000, 1'b1,
                  4'b0100, 8'h00, 8'h00, 8'h77, 8'h00, 4'b0100);

        // Strobe with no select is discarded
        do_strobe(4'b0000, 8'h99, 8'h99, 3, 4'b0000, 1'b0,
                  4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
        @(negedge clk);
        check_state("nosel", 8'h00, 8'h00, 8'h77, 8'h00, 4'b0100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000ns");
        $fatal(1, "timeout");
    end

endmodule
